// File: rtl/spike_gen_programmer_if.sv
// Host word channel plus programming channel around spike_gen_programmer.
// master = the programmer (accepts host words, initiates programming); slave = its environment.
interface spike_gen_programmer_if #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11
);
  localparam int NgenIdx = $clog2(Ngens);

  logic               in_v;
  logic [31:0]        in_d;
  logic               in_a;
  logic               prog_v;
  logic [NgenIdx-1:0] prog_gen_idx;
  logic [Nperiod-1:0] prog_period;
  logic [Nperiod-1:0] prog_ticks;
  logic [Ntag-1:0]    prog_tag;
  logic               prog_a;

  modport master (
    input  in_v, in_d, prog_a,
    output in_a, prog_v, prog_gen_idx, prog_period, prog_ticks, prog_tag
  );

  modport slave (
    output in_v, in_d, prog_a,
    input  in_a, prog_v, prog_gen_idx, prog_period, prog_ticks, prog_tag
  );
endinterface

// File: rtl/spike_gen_programmer.sv
// Host word decoder: two-word PROG packets -> one programming transaction; CONF words -> gens_used/gens_en.
// Optional macro SPIKE_PROG_RANGE_CHECK_EN rejects out-of-range gen_idx and gens_used fields.
module spike_gen_programmer #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11
) (
  input  logic                     clk,
  input  logic                     reset_n,
  spike_gen_programmer_if.master   bus,
  output logic [$clog2(Ngens):0]   gens_used,
  output logic [Ngens-1:0]         gens_en,
  output logic [7:0]               err_count
);
  localparam int NgenIdx = $clog2(Ngens);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BODY = 2'd1;
  localparam logic [1:0] S_ISSUE     = 2'd2;

  localparam logic [3:0] OP_PROG_HDR = 4'h1;
  localparam logic [3:0] OP_CONF     = 4'h3;

  logic [1:0]         r_state;
  logic [NgenIdx-1:0] r_gen_idx;
  logic [Nperiod-1:0] r_period;
  logic [Nperiod-1:0] r_ticks;
  logic [Ntag-1:0]    r_tag;
  logic               r_bad;
  logic [NgenIdx:0]   r_gens_used;
  logic [Ngens-1:0]   r_gens_en;
  logic [7:0]         r_err_count;

  logic               w_word_acc;
  logic [3:0]         w_opcode;
  logic [NgenIdx:0]   w_conf_used;
  logic               w_hdr_bad;
  logic               w_conf_bad;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_word_acc  = bus.in_v && bus.in_a;
  assign w_opcode    = bus.in_d[31:28];
  assign w_conf_used = bus.in_d[16+NgenIdx:16];

`ifdef SPIKE_PROG_RANGE_CHECK_EN
  assign w_hdr_bad  = (bus.in_d[18:11] >= 8'(Ngens));
  assign w_conf_bad = (w_conf_used > (NgenIdx+1)'(Ngens));
`else
  assign w_hdr_bad  = 1'b0;
  assign w_conf_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_gen_idx   <= '0;
      r_period    <= '0;
      r_ticks     <= '0;
      r_tag       <= '0;
      r_bad       <= 1'b0;
      r_gens_used <= '0;
      r_gens_en   <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_word_acc) begin
            case (w_opcode)
              OP_PROG_HDR: begin
                // Header index is truncated to the generator index width; range errors are flagged separately.
                r_gen_idx <= bus.in_d[11 +: NgenIdx];
                r_tag     <= bus.in_d[Ntag-1:0];
                r_bad     <= w_hdr_bad;
                r_state   <= S_WAIT_BODY;
              end
              OP_CONF: begin
                if (w_conf_bad) begin
                  r_err_count <= sat_inc(r_err_count);
                end else begin
                  r_gens_used <= w_conf_used;
                  r_gens_en   <= bus.in_d[Ngens-1:0];
                end
              end
              default: r_err_count <= sat_inc(r_err_count);
            endcase
          end
        end
        S_WAIT_BODY: begin
          if (w_word_acc) begin
            r_period <= bus.in_d[31:16];
            r_ticks  <= bus.in_d[15:0];
            // A flagged packet still consumes its body, then is discarded without issuing.
            if (r_bad) begin
              r_err_count <= sat_inc(r_err_count);
              r_state     <= S_IDLE;
            end else begin
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (bus.prog_a) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_a         = (r_state != S_ISSUE);
  assign bus.prog_v       = (r_state == S_ISSUE);
  assign bus.prog_gen_idx = r_gen_idx;
  assign bus.prog_period  = r_period;
  assign bus.prog_ticks   = r_ticks;
  assign bus.prog_tag     = r_tag;
  assign gens_used        = r_gens_used;
  assign gens_en          = r_gens_en;
  assign err_count        = r_err_count;

endmodule
